dark_fetch_initiator: RTL

//  Instruction-fetch initiator on darkbus. Drives the producer side of the bus
//  (addr/en) toward a 1-cycle-latency responder (instruction ROM, valid = en delayed 1 cycle).

---
 rtl/dark_pkg.sv | 21 ++
 rtl/darkbus.sv | 18 +
 rtl/dark_fetch_fifo.sv | 95 +++++++++
 rtl/dark_fetch_initiator.sv | 108 ++++++++++
 4 files changed

// File: rtl/dark_pkg.sv
// Shared darkbus fetch types.
//   word_t         32-bit machine word
//   NOP_INSN       word shown on the fetch output while the prefetch FIFO is empty
//   fetch_entry_t  one prefetch FIFO slot: {pc, insn}
//   pc_align       clears the byte-offset bits of a fetch address
package dark_pkg;

  typedef logic [31:0] word_t;

  localparam word_t NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    word_t pc;
    word_t insn;
  } fetch_entry_t;

  function automatic word_t pc_align(input word_t pc);
    return pc & ~word_t'(3);
  endfunction

endpackage

// File: rtl/darkbus.sv
// darkbus: single-beat request/response bus with fixed 1-cycle response latency.
//   addr[31:0]  producer -> consumer  request address
//   en          producer -> consumer  request strobe
//   data[31:0]  consumer -> producer  response word
//   valid       consumer -> producer  response strobe (en delayed one cycle)
// Modports: prod (fetch initiator side), cons (responder side).
interface darkbus;
  import dark_pkg::*;

  word_t addr;
  logic  en;
  word_t data;
  logic  valid;

  modport prod (output addr, output en, input data, input valid);
  modport cons (input addr, input en, output data, output valid);

endinterface

// File: rtl/dark_fetch_fifo.sv
// Prefetch FIFO holding {pc, insn} entries for the core front end.
//   clk, rst_n  clock / async active-low reset
//   push        write push_data at the tail
//   push_data   entry to write
//   pop         remove the head (ignored when empty)
//   flush       empty the FIFO; wins over push and pop in the same cycle
//   count       current occupancy, 0..DEPTH
//   head        head entry; {last shown pc, NOP_INSN} while empty
//   empty/full  occupancy flags
module dark_fetch_fifo
  import dark_pkg::*;
#(
  parameter int    DEPTH    = 4,
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output fetch_entry_t                 head,
  output logic                         empty,
  output logic                         full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    mem_q [DEPTH];
  fetch_entry_t    mem_d [DEPTH];
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  word_t           last_pc_q, last_pc_d;
  logic            do_pop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign count  = cnt_q;
  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CW'(DEPTH));
  assign do_pop = pop && !empty;

  // While empty the pc output keeps the last head the core saw.
  assign head = empty ? '{pc: last_pc_q, insn: NOP_INSN} : mem_q[rd_q];

  always_comb begin
    mem_d     = mem_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    last_pc_d = empty ? last_pc_q : mem_q[rd_q].pc;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_data;
        wr_d        = ptr_inc(wr_q);
      end
      if (do_pop) rd_d = ptr_inc(rd_q);
      cnt_d = cnt_q + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q      <= '0;
      wr_q      <= '0;
      cnt_q     <= '0;
      last_pc_q <= RESET_PC;
    end else begin
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
      last_pc_q <= last_pc_d;
    end
  end

  // Storage needs no reset: it is never observed while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !flush))
    else $error("dark_fetch_fifo overflow");

endmodule

// File: rtl/dark_fetch_initiator.sv
// Instruction-fetch initiator on darkbus.
//   XCLK            clock, rising edge
//   XRES            async active-low reset
//   BUS             darkbus.prod: addr/en out, data/valid in (1-cycle responder)
//   redirect_valid  pulse: flush and restart fetch at redirect_pc
//   redirect_pc     new fetch address (low two bits ignored)
//   instr_ready     core takes the head entry
//   instr_valid     prefetch FIFO non-empty
//   instr_data      head instruction (NOP while empty)
//   instr_pc        head pc (last head pc while empty)
// Issue is credit based: a request is only sent when the FIFO is guaranteed
// to have room for its response, so the response path never back-pressures.
module dark_fetch_initiator
  import dark_pkg::*;
#(
  parameter int    DEPTH    = 4,
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic  XCLK,
  input  logic  XRES,
  darkbus.prod  BUS,
  input  logic  redirect_valid,
  input  word_t redirect_pc,
  input  logic  instr_ready,
  output logic  instr_valid,
  output word_t instr_data,
  output word_t instr_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  word_t         fetch_pc_q, fetch_pc_d;
  word_t         req_pc_q,   req_pc_d;
  logic          inflight_q, inflight_d;
  logic          drop_q,     drop_d;

  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head;
  logic          fifo_empty, fifo_full;
  logic          fifo_push, fifo_pop;
  logic [CW:0]   credit_used;
  logic          issue;

  // Entries held plus the one response that may still be on its way.
  assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign issue       = (credit_used < (CW+1)'(DEPTH));

  // Internal state advances on 'issue'; only the bus strobe is masked by
  // reset so en reads 0 the moment XRES drops, not one edge later.
  assign BUS.en   = issue && XRES;
  assign BUS.addr = fetch_pc_q;

  // A response is stale if it answers a request issued in a redirect cycle
  // (drop_q) or arrives during the redirect cycle itself.
  assign fifo_push = BUS.valid && inflight_q && !drop_q && !redirect_valid;
  assign fifo_pop  = instr_valid && instr_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    drop_d     = redirect_valid;
    if (issue) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      req_pc_d   = fetch_pc_q;
    end
    if (redirect_valid) fetch_pc_d = pc_align(redirect_pc);
  end

  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  dark_fetch_fifo #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_fifo (
    .clk       (XCLK),
    .rst_n     (XRES),
    .push      (fifo_push),
    .push_data ('{pc: req_pc_q, insn: BUS.data}),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .count     (fifo_count),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign instr_valid = !fifo_empty;
  assign instr_data  = fifo_head.insn;
  assign instr_pc    = fifo_head.pc;

  a_no_issue_when_full : assert property (@(posedge XCLK) disable iff (!XRES)
    !(fifo_full && issue))
    else $error("dark_fetch_initiator issued with FIFO full");

endmodule
